// File: rtl/tx_symbol_framer.sv
// Transmit framer ahead of the 8b/10b encoder: turns a valid/ready byte stream into {K,data} symbols.
// Define TX_SYMBOL_FRAMER_CRC_EN to append a CRC-16-CCITT trailer (high byte first) to each frame.
module tx_symbol_framer #(
  parameter int unsigned MAX_LEN  = 256,
  parameter int unsigned IDLE_MIN = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [8:0]  sym,
  output logic        len_err,
  output logic [15:0] frame_cnt,
  output logic        busy
);

  localparam logic [8:0] SYM_COMMA = 9'h1BC;
  localparam logic [8:0] SYM_SOF   = 9'h1FB;
  localparam logic [8:0] SYM_EOF   = 9'h1FD;
  localparam logic [8:0] SYM_ABORT = 9'h1FE;
  localparam logic [8:0] SYM_FILL  = 9'h17C;

  localparam int unsigned        GAP_W   = $clog2(IDLE_MIN + 1);
  localparam logic [GAP_W-1:0]   GAP_MAX = GAP_W'(IDLE_MIN);
  localparam logic [15:0]        LEN_MAX = 16'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SOF,
    S_DATA,
    S_EOF,
    S_ABORT,
    S_DISCARD
`ifdef TX_SYMBOL_FRAMER_CRC_EN
    , S_CRC_HI,
    S_CRC_LO
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [8:0]       sym_q, sym_d;
  logic             len_err_q, len_err_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic [15:0]      count_q, count_d;
  logic [GAP_W-1:0] gap_q, gap_d, gap_inc;
  logic             accept;
  logic             do_sof, do_abort;

`ifdef TX_SYMBOL_FRAMER_CRC_EN
  logic [15:0] crc_q, crc_d;

  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      if (c[15] ^ data[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
      else                 c = {c[14:0], 1'b0};
    end
    return c;
  endfunction
`endif

  assign s_ready   = ((state_q == S_DATA) && (count_q < LEN_MAX)) || (state_q == S_DISCARD);
  assign busy      = (state_q != S_IDLE) && (state_q != S_DISCARD);
  assign accept    = s_valid && s_ready;
  assign gap_inc   = (gap_q >= GAP_MAX) ? gap_q : gap_q + GAP_W'(1);
  assign sym       = sym_q;
  assign len_err   = len_err_q;
  assign frame_cnt = frame_cnt_q;

  // IDLE and a full DATA perform the SOF/ABORT load on the same edge so no extra symbol slips in.
  always_comb begin
    state_d     = state_q;
    sym_d       = SYM_COMMA;
    len_err_d   = 1'b0;
    frame_cnt_d = frame_cnt_q;
    count_d     = count_q;
    gap_d       = gap_q;
    do_sof      = 1'b0;
    do_abort    = 1'b0;
`ifdef TX_SYMBOL_FRAMER_CRC_EN
    crc_d       = crc_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (s_valid && (gap_q >= GAP_MAX)) do_sof = 1'b1;
        else                              gap_d  = gap_inc;
      end
      S_SOF: do_sof = 1'b1;
      S_DATA: begin
        if (count_q >= LEN_MAX) begin
          do_abort = 1'b1;
        end else if (accept) begin
          sym_d   = {1'b0, s_data};
          count_d = count_q + 16'd1;
`ifdef TX_SYMBOL_FRAMER_CRC_EN
          crc_d   = crc16_step(crc_q, s_data);
          state_d = s_last ? S_CRC_HI : S_DATA;
`else
          state_d = s_last ? S_EOF : S_DATA;
`endif
        end else begin
          sym_d = SYM_FILL;
        end
      end
`ifdef TX_SYMBOL_FRAMER_CRC_EN
      S_CRC_HI: begin
        sym_d   = {1'b0, crc_q[15:8]};
        state_d = S_CRC_LO;
      end
      S_CRC_LO: begin
        sym_d   = {1'b0, crc_q[7:0]};
        state_d = S_EOF;
      end
`endif
      S_EOF: begin
        sym_d       = SYM_EOF;
        frame_cnt_d = frame_cnt_q + 16'd1;
        gap_d       = '0;
        state_d     = S_IDLE;
      end
      S_ABORT: do_abort = 1'b1;
      S_DISCARD: begin
        gap_d = gap_inc;
        if (accept && s_last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (do_sof) begin
      sym_d   = SYM_SOF;
      count_d = '0;
`ifdef TX_SYMBOL_FRAMER_CRC_EN
      crc_d   = 16'hFFFF;
`endif
      state_d = S_DATA;
    end
    if (do_abort) begin
      sym_d     = SYM_ABORT;
      len_err_d = 1'b1;
      gap_d     = '0;
      state_d   = S_DISCARD;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      sym_q       <= SYM_COMMA;
      len_err_q   <= 1'b0;
      frame_cnt_q <= '0;
      count_q     <= '0;
      gap_q       <= GAP_MAX;
`ifdef TX_SYMBOL_FRAMER_CRC_EN
      crc_q       <= 16'hFFFF;
`endif
    end else begin
      state_q     <= state_d;
      sym_q       <= sym_d;
      len_err_q   <= len_err_d;
      frame_cnt_q <= frame_cnt_d;
      count_q     <= count_d;
      gap_q       <= gap_d;
`ifdef TX_SYMBOL_FRAMER_CRC_EN
      crc_q       <= crc_d;
`endif
    end
  end

endmodule

// File: tb/tb_tx_symbol_framer.sv
// Self-checking bench for tx_symbol_framer: directed and random frames compared cycle by cycle
// against a symbol-stream model built from the framing rules.
module tb_tx_symbol_framer;

  localparam int MAX_LEN  = 10;
  localparam int IDLE_MIN = 2;
`ifdef TX_SYMBOL_FRAMER_CRC_EN
  localparam bit CRC_ON = 1'b1;
  localparam int TRAIL  = 3;
`else
  localparam bit CRC_ON = 1'b0;
  localparam int TRAIL  = 1;
`endif

  localparam logic [8:0] COMMA = 9'h1BC;
  localparam logic [8:0] SOF   = 9'h1FB;
  localparam logic [8:0] EOF   = 9'h1FD;
  localparam logic [8:0] ABORT = 9'h1FE;
  localparam logic [8:0] FILL  = 9'h17C;

  typedef struct packed {
    logic [8:0]  sym;
    logic        len_err;
    logic        busy;
    logic        rdy;
    logic [15:0] fcnt;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;
  logic [8:0]  sym;
  logic        len_err;
  logic [15:0] frame_cnt;
  logic        busy;

  always #5 clk = ~clk;

  tx_symbol_framer #(.MAX_LEN(MAX_LEN), .IDLE_MIN(IDLE_MIN)) dut (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .sym(sym), .len_err(len_err), .frame_cnt(frame_cnt), .busy(busy)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  bit          stuck    = 1'b0;
  bit          mon_en   = 1'b0;
  obs_t        exp_q[$];
  obs_t        act_q[$];
  obs_t        mon_s;
  logic [7:0]  fr_b[$];
  int          fr_g[$];
  int          prev_kind = 0;
  int          prev_r    = 0;
  logic [15:0] model_frames = 16'd0;

  always @(negedge clk) begin
    if (mon_en) begin
      mon_s.sym     = sym;
      mon_s.len_err = len_err;
      mon_s.busy    = busy;
      mon_s.rdy     = s_ready;
      mon_s.fcnt    = frame_cnt;
      act_q.push_back(mon_s);
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Byte-wise CCITT formulation, independent of a bit-serial shift register.
  function automatic logic [15:0] model_crc(input logic [7:0] msg[$]);
    logic [15:0] c;
    logic [7:0]  x;
    c = 16'hFFFF;
    foreach (msg[i]) begin
      x = c[15:8] ^ msg[i];
      x = x ^ (x >> 4);
      c = {c[7:0], 8'h00} ^ {x[3:0], 12'h000} ^ {3'b000, x, 5'b00000} ^ {8'h00, x};
    end
    return c;
  endfunction

  function automatic void push_exp(input logic [8:0] s, input logic rdy);
    obs_t e;
    if (s == EOF) model_frames++;
    e.sym     = s;
    e.len_err = (s == ABORT);
    e.busy    = !((s == COMMA) || (s == EOF) || (s == ABORT));
    e.rdy     = rdy;
    e.fcnt    = model_frames;
    exp_q.push_back(e);
  endfunction

  // k = cycles s_valid stays low before the first byte of this frame is offered.
  function automatic void model_frame(input int k);
    int n, m, lead, g;
    logic [15:0] crc;
    n = fr_b.size();
    m = (n < MAX_LEN) ? n : MAX_LEN;
    case (prev_kind)
      0: lead = k;
      1: lead = ((k - TRAIL) > IDLE_MIN) ? (k - TRAIL) : IDLE_MIN;
      default: begin
        g    = (prev_r < IDLE_MIN) ? prev_r : IDLE_MIN;
        lead = (k > (IDLE_MIN - g)) ? k : (IDLE_MIN - g);
      end
    endcase
    repeat (lead) push_exp(COMMA, 1'b0);
    push_exp(SOF, 1'b1);
    for (int i = 0; i < m; i++) begin
      push_exp({1'b0, fr_b[i]}, (i != n - 1) && (i + 1 < MAX_LEN));
      if (i < m - 1) repeat (fr_g[i]) push_exp(FILL, 1'b1);
    end
    if (n <= MAX_LEN) begin
      if (CRC_ON) begin
        crc = model_crc(fr_b);
        push_exp({1'b0, crc[15:8]}, 1'b0);
        push_exp({1'b0, crc[7:0]}, 1'b0);
      end
      push_exp(EOF, 1'b0);
      prev_kind = 1;
    end else begin
      push_exp(ABORT, 1'b1);
      for (int j = 0; j < n - MAX_LEN; j++) push_exp(COMMA, j != (n - MAX_LEN - 1));
      prev_kind = 2;
      prev_r    = n - MAX_LEN;
    end
  endfunction

  // Called at a negedge; returns at the negedge following the accepting posedge.
  task automatic wait_accept();
    bit done;
    done = 1'b0;
    for (int c = 0; c < 64 && !done && !stuck; c++) begin
      if (s_ready === 1'b1) begin
        @(posedge clk);
        @(negedge clk);
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!done && !stuck) begin
      stuck = 1'b1;
      check_output("accept_timeout", {15'd0, done}, 16'd1);
    end
  endtask

  task automatic apply_stimulus(input int k);
    int n, m;
    n = fr_b.size();
    m = (n < MAX_LEN) ? n : MAX_LEN;
    model_frame(k);
    s_valid = 1'b0;
    s_last  = 1'b0;
    repeat (k) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      s_data  = fr_b[i];
      s_last  = (i == n - 1);
      s_valid = 1'b1;
      wait_accept();
      s_valid = 1'b0;
      s_last  = 1'b0;
      if (i < m - 1) repeat (fr_g[i]) @(negedge clk);
    end
  endtask

  function automatic void zero_gaps();
    fr_g.delete();
    foreach (fr_b[i]) fr_g.push_back(0);
  endfunction

  initial begin
    logic [7:0]  one_b[$];
    logic [15:0] c1;
    int          n;

    reset   = 1'b1;
    s_valid = 1'b0;
    s_data  = 8'h00;
    s_last  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("rst_sym",       16'(sym),       16'(COMMA));
    check_output("rst_s_ready",   16'(s_ready),   16'd0);
    check_output("rst_busy",      16'(busy),      16'd0);
    check_output("rst_len_err",   16'(len_err),   16'd0);
    check_output("rst_frame_cnt", frame_cnt,      16'd0);
    reset = 1'b0;
    #1 mon_en = 1'b1;

    // Idle commas after reset, then a continuous three-byte frame.
    fr_b = '{8'h11, 8'h22, 8'h33};
    zero_gaps();
    apply_stimulus(10);

    // Same payload back-to-back with two underrun cycles after the first byte.
    fr_g = '{2, 0, 0};
    apply_stimulus(0);

    fr_b = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    zero_gaps();
    apply_stimulus(0);

    // Oversized frame: abort after MAX_LEN bytes, remainder discarded.
    fr_b.delete();
    for (int i = 0; i < MAX_LEN + 2; i++) fr_b.push_back(8'hA0 + 8'(i));
    zero_gaps();
    fr_g[3] = 1;
    apply_stimulus(1);

    // Exactly MAX_LEN bytes is still a legal frame.
    fr_b.delete();
    for (int i = 0; i < MAX_LEN; i++) fr_b.push_back(8'hC0 + 8'(i));
    zero_gaps();
    apply_stimulus(0);

    fr_b = '{8'h5A};
    zero_gaps();
    apply_stimulus(3);

    for (int f = 0; f < 30; f++) begin
      n = $urandom_range(1, MAX_LEN + 3);
      fr_b.delete();
      fr_g.delete();
      for (int i = 0; i < n; i++) begin
        fr_b.push_back(8'($urandom));
        fr_g.push_back(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0);
      end
      apply_stimulus($urandom_range(0, 5));
    end

    repeat (IDLE_MIN) push_exp(COMMA, 1'b0);
    s_valid = 1'b0;
    repeat (IDLE_MIN + 8) @(negedge clk);
    mon_en = 1'b0;

    check_output("stream_len", 16'(act_q.size() >= exp_q.size()), 16'd1);
    for (int i = 0; i < exp_q.size() && i < act_q.size(); i++) begin
      check_output($sformatf("sym@%0d", i),       16'(act_q[i].sym),     16'(exp_q[i].sym));
      check_output($sformatf("len_err@%0d", i),   16'(act_q[i].len_err), 16'(exp_q[i].len_err));
      check_output($sformatf("busy@%0d", i),      16'(act_q[i].busy),    16'(exp_q[i].busy));
      check_output($sformatf("s_ready@%0d", i),   16'(act_q[i].rdy),     16'(exp_q[i].rdy));
      check_output($sformatf("frame_cnt@%0d", i), act_q[i].fcnt,         exp_q[i].fcnt);
    end
    check_output("frame_cnt_end", frame_cnt, model_frames);

    // Reset in the middle of DATA, then a frame starting on the first edge after release.
    s_data  = 8'hC3;
    s_last  = 1'b0;
    s_valid = 1'b1;
    wait_accept();
    s_data = 8'hC4;
    wait_accept();
    s_valid = 1'b0;
    reset   = 1'b1;
    @(negedge clk);
    check_output("midrst_sym",       16'(sym),     16'(COMMA));
    check_output("midrst_s_ready",   16'(s_ready), 16'd0);
    check_output("midrst_busy",      16'(busy),    16'd0);
    check_output("midrst_len_err",   16'(len_err), 16'd0);
    check_output("midrst_frame_cnt", frame_cnt,    16'd0);
    reset   = 1'b0;
    s_data  = 8'h5A;
    s_last  = 1'b1;
    s_valid = 1'b1;
    @(negedge clk);
    check_output("sof_after_reset", 16'(sym), 16'(SOF));
    wait_accept();
    s_valid = 1'b0;
    s_last  = 1'b0;
    check_output("single_byte", 16'(sym), 16'h005A);
    @(negedge clk);
    one_b = '{8'h5A};
    c1    = model_crc(one_b);
    check_output("single_trailer", 16'(sym), CRC_ON ? {8'h00, c1[15:8]} : 16'(EOF));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
